// File: rtl/inv_key_evolution.sv
//==============================================================================
// Module   : inv_key_evolution
// Purpose  : Reverse AES-128 key schedule, steps round 10 back to round 0.
//            Optional round-key store enabled by INV_KEY_EVOLUTION_STORE_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module inv_key_evolution (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_en,
  input  logic         load_key,
  input  logic [127:0] key,
`ifdef INV_KEY_EVOLUTION_STORE_EN
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key,
`endif
  output logic [127:0] evolutioned_key_out,
  output logic [3:0]   round_out,
  output logic         key_valid,
  output logic         done
);

  localparam logic [7:0] c_rcon_last = 8'h36;
  localparam logic [3:0] c_round_last = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state, w_state_nxt;
  logic [127:0] r_key, w_key_nxt, w_prev_key;
  logic [3:0]   r_round, w_round_nxt;
  logic         r_valid, w_valid_nxt;
  logic         r_done, w_done_nxt;
  logic [7:0]   r_rcon, w_rcon_nxt, w_rcon_prev;
  logic         w_step;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box: x^254 (multiplicative inverse, 0 maps to 0) then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [31:0] w_w4, w_w5, w_w6, w_w7;
  logic [31:0] w_w0, w_w1, w_w2, w_w3;

  assign w_w4 = r_key[127:96];
  assign w_w5 = r_key[95:64];
  assign w_w6 = r_key[63:32];
  assign w_w7 = r_key[31:0];
  assign w_w3 = w_w7 ^ w_w6;
  assign w_w2 = w_w6 ^ w_w5;
  assign w_w1 = w_w5 ^ w_w4;
  assign w_w0 = w_w4 ^ sub_word({w_w3[23:0], w_w3[31:24]}) ^ {r_rcon, 24'h000000};
  assign w_prev_key = {w_w0, w_w1, w_w2, w_w3};

  // rcon * x^-1 in GF(2^8)
  assign w_rcon_prev = r_rcon[0] ? (((r_rcon ^ 8'h1B) >> 1) | 8'h80) : (r_rcon >> 1);

  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_round_nxt = r_round;
    w_valid_nxt = r_valid;
    w_done_nxt  = r_done;
    w_rcon_nxt  = r_rcon;
    w_step      = 1'b0;
    if (load_key) begin
      w_state_nxt = S_RUN;
      w_key_nxt   = key;
      w_round_nxt = c_round_last;
      w_valid_nxt = 1'b1;
      w_done_nxt  = 1'b0;
      w_rcon_nxt  = c_rcon_last;
    end else if (r_state == S_RUN && clk_en) begin
      w_step      = 1'b1;
      w_key_nxt   = w_prev_key;
      w_round_nxt = r_round - 4'd1;
      w_rcon_nxt  = w_rcon_prev;
      if (r_round == 4'd1) begin
        w_state_nxt = S_DONE;
        w_done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_round <= 4'd0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_rcon  <= c_rcon_last;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_round <= w_round_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_rcon  <= w_rcon_nxt;
    end
  end

  assign evolutioned_key_out = r_key;
  assign round_out           = r_round;
  assign key_valid           = r_valid;
  assign done                = r_done;

`ifdef INV_KEY_EVOLUTION_STORE_EN
  logic [127:0] r_store [0:10];
  logic [3:0]   w_store_idx;

  // In RUN the round is 1..10, so the step target index stays within 0..9.
  assign w_store_idx = r_round - 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 11; i++) r_store[i] <= '0;
    end else if (load_key) begin
      r_store[c_round_last] <= key;
    end else if (w_step) begin
      r_store[w_store_idx] <= w_prev_key;
    end
  end

  assign rd_key = (rd_addr > c_round_last) ? '0 : r_store[rd_addr];
`endif

endmodule

`default_nettype wire
